// File: rtl/fb_dvi_timing.sv
// DVI raster timing generator with an RGB555 pixel FIFO sink.
// Stream frames are locked to the raster so a start-flagged word always lands on pixel (0,0).
module fb_dvi_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic [14:0] iFB_DATA,
  input  logic        iFB_DV,
  input  logic        iFB_START,
  output logic        oFB_READY,
  output logic [7:0]  oRED,
  output logic [7:0]  oGRN,
  output logic [7:0]  oBLU,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic        oUNDERRUN,
  output logic        oOVERFLOW
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_READY = (AW+1)'(FIFO_DEPTH - 3);

  typedef enum logic [1:0] {ST_SEEK, ST_WAIT, ST_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [HW-1:0]   r_hcnt;
  logic [VW-1:0]   r_vcnt;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count, w_count_next;
  logic            r_ready, r_de, r_hs, r_vs, r_underrun, r_overflow;
  logic [7:0]      r_red, r_grn, r_blu;

  logic            w_active, w_last, w_origin, w_hs_win, w_vs_win;
  logic            w_empty, w_full, w_push, w_pop, w_show, w_underrun;
  logic [15:0]     w_head;
  logic [23:0]     w_rgb;

  assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_last   = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);
  assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_hs_win = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  assign w_vs_win = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_push   = iFB_DV && !w_full;
  assign w_head   = r_mem[r_rptr];
  // Replicate the top bits so full-scale 5-bit maps to full-scale 8-bit.
  assign w_rgb    = {w_head[14:10], w_head[14:12], w_head[9:5], w_head[9:7],
                     w_head[4:0], w_head[4:2]};

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_show       = 1'b0;
    w_underrun   = 1'b0;
    case (r_state)
      ST_SEEK: begin
        if (!w_empty) begin
          if (w_head[15]) w_state_next = ST_WAIT;
          else            w_pop        = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_last) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_active) begin
          if (w_empty) begin
            w_underrun   = 1'b1;
            w_state_next = ST_SEEK;
          end else if (w_head[15] && !w_origin) begin
            w_state_next = ST_WAIT;
          end else if (!w_head[15] && w_origin) begin
            w_state_next = ST_SEEK;
          end else begin
            w_pop  = 1'b1;
            w_show = 1'b1;
          end
        end
      end
      default: w_state_next = ST_SEEK;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESETn && w_push)
      r_mem[r_wptr] <= {iFB_START, iFB_DATA};
  end

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      r_state    <= ST_SEEK;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_de       <= 1'b0;
      r_hs       <= !HS_POL;
      r_vs       <= !VS_POL;
      r_red      <= 8'h00;
      r_grn      <= 8'h00;
      r_blu      <= 8'h00;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_hcnt == H_LAST) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count    <= w_count_next;
      r_ready    <= (w_count_next <= CNT_READY);
      r_de       <= w_active;
      r_hs       <= w_hs_win ? HS_POL : !HS_POL;
      r_vs       <= w_vs_win ? VS_POL : !VS_POL;
      r_red      <= w_show ? w_rgb[23:16] : 8'h00;
      r_grn      <= w_show ? w_rgb[15:8]  : 8'h00;
      r_blu      <= w_show ? w_rgb[7:0]   : 8'h00;
      r_underrun <= w_underrun;
      r_overflow <= iFB_DV && w_full;
    end
  end

  assign oFB_READY = r_ready;
  assign oRED      = r_red;
  assign oGRN      = r_grn;
  assign oBLU      = r_blu;
  assign oHS       = r_hs;
  assign oVS       = r_vs;
  assign oDE       = r_de;
  assign oUNDERRUN = r_underrun;
  assign oOVERFLOW = r_overflow;

endmodule

// File: tb/tb_fb_dvi_timing.sv
// Scoreboard bench for fb_dvi_timing on a 14x7 raster with an 8-entry FIFO.
// Stimulus schedules expectations by clock tick; a negedge monitor consumes them.
module tb_fb_dvi_timing;

  localparam int HT     = 14;
  localparam int FT     = 98;
  localparam int MAXI   = 1024;
  localparam int K_RGB  = 0, K_SYNC = 1, K_RST = 2, K_READY = 3, K_UND = 4;
  localparam int K_OVF  = 5, K_UCNT = 6, K_OCNT = 7, K_NBLK = 8;
  localparam logic [31:0] RSTV = {2'b00, 6'b011000, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] fb_data = '0;
  logic        fb_dv = 1'b0;
  logic        fb_start = 1'b0;
  logic        ready, hs, vs, de, und, ovf;
  logic [7:0]  red, grn, blu;

  always #5 clk = ~clk;

  fb_dvi_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_DEPTH(8)
  ) dut (
    .iCLK(clk), .iRESETn(rst_n), .iFB_DATA(fb_data), .iFB_DV(fb_dv),
    .iFB_START(fb_start), .oFB_READY(ready), .oRED(red), .oGRN(grn),
    .oBLU(blu), .oHS(hs), .oVS(vs), .oDE(de), .oUNDERRUN(und), .oOVERFLOW(ovf)
  );

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int          it_t [MAXI];
  int          it_k [MAXI];
  logic [31:0] it_v [MAXI];
  bit          it_done [MAXI];
  int          n_items = 0;
  int          base = 0;
  int          tests = 0, failed = 0;
  int          und_cnt = 0, ovf_cnt = 0, nonblk = 0;

  function automatic string kname(input int k);
    case (k)
      K_RGB:   return "rgb";
      K_SYNC:  return "de_hs_vs";
      K_RST:   return "reset_values";
      K_READY: return "fb_ready";
      K_UND:   return "underrun_pulse";
      K_OVF:   return "overflow_pulse";
      K_UCNT:  return "underrun_total";
      K_OCNT:  return "overflow_total";
      default: return "rgb_outside_de";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RGB:   return {7'd0, de, red, grn, blu};
      K_SYNC:  return {29'd0, de, hs, vs};
      K_RST:   return {2'd0, de, hs, vs, ready, und, ovf, red, grn, blu};
      K_READY: return {31'd0, ready};
      K_UND:   return {31'd0, und};
      K_OVF:   return {31'd0, ovf};
      K_UCNT:  return 32'(und_cnt);
      K_OCNT:  return 32'(ovf_cnt);
      default: return 32'(nonblk);
    endcase
  endfunction

  always @(negedge clk) begin
    int nt;
    int nf;
    logic [31:0] act;
    nt = 0;
    nf = 0;
    for (int i = 0; i < n_items; i++) begin
      if (!it_done[i] && it_t[i] <= tick) begin
        act = actual(it_k[i]);
        nt++;
        if (it_t[i] < tick) begin
          nf++;
          $display("FAIL %s at tick %0d: never sampled, required %h", kname(it_k[i]), it_t[i], it_v[i]);
        end else if (act !== it_v[i]) begin
          nf++;
          $display("FAIL %s at tick %0d: got %h, required %h", kname(it_k[i]), tick, act, it_v[i]);
        end
        it_done[i] <= 1'b1;
      end
    end
    tests  <= tests + nt;
    failed <= failed + nf;
    if (und === 1'b1) und_cnt <= und_cnt + 1;
    if (ovf === 1'b1) ovf_cnt <= ovf_cnt + 1;
    if (de === 1'b0 && {red, grn, blu} !== 24'h0 && rst_n) nonblk <= nonblk + 1;
  end

  function automatic logic [14:0] val(input int sel, input int i);
    logic [4:0] i5;
    i5 = 5'(i);
    case (sel)
      1:       return 15'(i);
      2:       return {i5, ~i5, 5'h0A};
      3:       return (i == 0) ? 15'h7FFF : (i == 1) ? 15'h4210 : 15'h1234 + 15'(i);
      default: return 15'h0100 + 15'(i * 273);
    endcase
  endfunction

  function automatic logic [23:0] rgb_of(input logic [14:0] p);
    return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
  endfunction

  function automatic int px(input int f, input int i);
    return f * FT + (i / 8) * HT + (i % 8);
  endfunction

  task automatic add(input int t, input int k, input logic [31:0] v);
    if (n_items < MAXI) begin
      it_t[n_items] = t;
      it_k[n_items] = k;
      it_v[n_items] = v;
      n_items++;
    end
  endtask

  task automatic exp_rgb(input int n, input logic [23:0] c);
    add(base + 1 + n, K_RGB, {8'h01, c});
  endtask

  task automatic exp_frame(input int f, input int sel, input int nshow, input int npush);
    for (int i = 0; i < npush; i++)
      exp_rgb(px(f, i), (i < nshow) ? rgb_of(val(sel, i)) : 24'h0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    base  = tick;
  endtask

  task automatic stream(input int nwords, input int sel, input int stop_tick);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < nwords && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (tick >= stop_tick) break;
      if (ready) begin
        fb_dv    = 1'b1;
        fb_start = (i == 0);
        fb_data  = val(sel, i);
        i++;
      end else begin
        fb_dv = 1'b0;
      end
    end
    @(negedge clk);
    fb_dv    = 1'b0;
    fb_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tf;
    // Power-up reset held, then lock/stall/relock sequence.
    repeat (3) @(negedge clk);
    add(tick + 1, K_RST, RSTV);
    release_rst();
    add(base + 1, K_READY, 32'd1);
    for (int n = 0; n < FT; n++) begin
      int h;
      int v;
      h = n % HT;
      v = n / HT;
      add(base + 1 + n, K_SYNC, {29'd0, (h < 8 && v < 4), !(h == 10 || h == 11), (v != 5)});
    end
    exp_frame(0, 1, 0, 32);
    exp_frame(1, 1, 32, 32);
    exp_rgb(px(1, 16), 24'h000084);
    exp_frame(2, 2, 20, 32);
    add(base + 1 + px(2, 20), K_UND, 32'd1);
    exp_frame(3, 3, 10, 10);
    exp_rgb(px(3, 0), 24'hFFFFFF);
    exp_rgb(px(3, 1), 24'h848484);

    stream(32, 1, 32'h3FFF_FFFF);
    stream(20, 2, 32'h3FFF_FFFF);
    while (tick < base + 1 + 230) @(negedge clk);
    stream(32, 3, base + 1 + 311);

    // Reset mid-line while the frame is being shown.
    rst_n = 1'b0;
    add(tick + 1, K_RST, RSTV);
    release_rst();

    // Relock, then overfill the FIFO while it holds a frame waiting for (0,0).
    add(base + 1, K_READY, 32'd1);
    add(base + 1 + 8, K_OVF, 32'd0);
    for (int j = 9; j <= 13; j++) add(base + 1 + j, K_OVF, 32'd1);
    add(base + 1 + 14, K_OVF, 32'd0);
    add(base + 1 + 13, K_READY, 32'd0);
    exp_frame(0, 4, 0, 32);
    exp_frame(1, 4, 8, 32);
    add(base + 1 + px(1, 8), K_UND, 32'd1);
    tf = base + 1 + px(1, 31) + 5;
    add(tf, K_UCNT, 32'd2);
    add(tf, K_OCNT, 32'd5);
    add(tf, K_NBLK, 32'd0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      fb_dv    = 1'b1;
      fb_start = (i == 0);
      fb_data  = val(4, i);
    end
    @(negedge clk);
    fb_dv    = 1'b0;
    fb_start = 1'b0;

    while (tick <= tf + 1) @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
